// File: rtl/count_evt_pkg.sv
// count_evt_pkg: shared event codes, record layout and widths for count_event_fifo.
package count_evt_pkg;
  localparam int TSTAMP_W = 8;
  localparam int EVT_CNT_W = 4;
  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_WRAP  = 2'b01,
    EVT_MATCH = 2'b10,
    EVT_BOTH  = 2'b11
  } evt_code_t;
  typedef struct packed {
    evt_code_t code;
    logic [EVT_CNT_W-1:0] count;
`ifdef COUNT_EVT_TSTAMP_EN
    logic [TSTAMP_W-1:0] tstamp;
`endif
  } evt_rec_t;
endpackage

// File: rtl/count_event_fifo_fifo.sv
// evt_fifo: synchronous FIFO, head read straight from storage; pushes while full without a pop are discarded.
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic do_push, do_pop;
  assign empty_o = level_q == '0;
  assign full_o = level_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i && !empty_o;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o = mem_q[rd_q];
  assign level_o = level_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      level_q <= level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/count_event_fifo.sv
// count_event_fifo: detects counter wrap / compare entry and queues event records for a valid/ready consumer.
// Optional COUNT_EVT_TSTAMP_EN adds an 8-bit timestamp to each record and the evt_tstamp port.
module count_event_fifo
  import count_evt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_W-1:0]       count_in,
  input  logic                   cmp_en,
  input  logic [CNT_W-1:0]       cmp_val,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [1:0]             evt_code,
  output logic [CNT_W-1:0]       evt_count,
  output logic                   evt_drop,
  input  logic                   drop_clr,
`ifdef COUNT_EVT_TSTAMP_EN
  output logic [TSTAMP_W-1:0]    evt_tstamp,
`endif
  output logic [$clog2(DEPTH):0] fifo_level
);
`ifdef COUNT_EVT_TSTAMP_EN
  localparam int REC_W = 2 + CNT_W + TSTAMP_W;
`else
  localparam int REC_W = 2 + CNT_W;
`endif
  logic [CNT_W-1:0] prev_q;
  logic prev_vld_q, drop_q, drop_d;
  logic wrap, match, push, full, empty, drop;
  evt_code_t code;
  logic [REC_W-1:0] rec_in, rec_out;
  assign wrap = prev_vld_q && prev_q == '1 && count_in == '0;
  assign match = cmp_en && count_in == cmp_val && (!prev_vld_q || prev_q != count_in);
  assign code = evt_code_t'({match, wrap});
  assign push = wrap || match;
  assign drop = push && full && !(evt_valid && evt_ready);
  assign drop_d = drop ? 1'b1 : drop_clr ? 1'b0 : drop_q;
`ifdef COUNT_EVT_TSTAMP_EN
  logic [TSTAMP_W-1:0] ts_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else ts_q <= ts_q + 1'b1;
  end
  assign rec_in = {code, count_in, ts_q};
  assign evt_tstamp = rec_out[TSTAMP_W-1:0];
`else
  assign rec_in = {code, count_in};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      prev_vld_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      prev_q <= count_in;
      prev_vld_q <= 1'b1;
      drop_q <= drop_d;
    end
  end
  evt_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (evt_ready),
    .din_i   (rec_in),
    .dout_o  (rec_out),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );
  assign evt_valid = !empty;
  assign evt_code = rec_out[REC_W-1 -: 2];
  assign evt_count = rec_out[REC_W-3 -: CNT_W];
  assign evt_drop = drop_q;
endmodule
